// File: rtl/demux_fifo_param.sv
// demux_fifo_param: steers a valid/ready stream into NUM_OUTPUTS independent FIFOs by select.
module demux_fifo_param #(
  parameter  int NUM_OUTPUTS = 2,
  parameter  int WIDTH       = 32,
  parameter  int DEPTH       = 2,
  localparam int SEL_WIDTH   = $clog2(NUM_OUTPUTS),
  localparam int PTR_WIDTH   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_WIDTH-1:0]   in_sel,
  input  logic [WIDTH-1:0]       in_data,
  output logic [NUM_OUTPUTS-1:0] out_valid,
  input  logic [NUM_OUTPUTS-1:0] out_ready,
  output logic [WIDTH-1:0]       out_data [NUM_OUTPUTS],
  output logic                   err_sel,
  output logic [7:0]             drop_count
);
  localparam logic [SEL_WIDTH:0] NUM_C   = (SEL_WIDTH+1)'(NUM_OUTPUTS);
  localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH+1)'(DEPTH);
  logic [WIDTH-1:0]       mem_q [NUM_OUTPUTS][DEPTH];
  logic [PTR_WIDTH-1:0]   wr_q  [NUM_OUTPUTS];
  logic [PTR_WIDTH-1:0]   rd_q  [NUM_OUTPUTS];
  logic [PTR_WIDTH:0]     cnt_q [NUM_OUTPUTS];
  logic [PTR_WIDTH:0]     cnt_d [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0] push, pop, full;
  logic [7:0]             drop_q;
  logic                   err_q, in_range, oor_push;
  always_comb begin
    in_range = {1'b0, in_sel} < NUM_C;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      full[i]      = cnt_q[i] == DEPTH_C;
      out_valid[i] = cnt_q[i] != '0;
      out_data[i]  = mem_q[i][rd_q[i]];
    end
    // No pass-through: a full channel stays not-ready even if it pops this cycle.
    in_ready = !flush && (!in_range || !full[in_sel]);
    oor_push = in_valid && in_ready && !in_range;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      push[i]  = in_valid && in_ready && in_range && in_sel == SEL_WIDTH'(i);
      pop[i]   = out_valid[i] && out_ready[i];
      cnt_d[i] = (push[i] && !pop[i]) ? cnt_q[i] + 1'b1 :
                 (pop[i] && !push[i]) ? cnt_q[i] - 1'b1 : cnt_q[i];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '{default: '0};
      wr_q   <= '{default: '0};
      rd_q   <= '{default: '0};
      cnt_q  <= '{default: '0};
      drop_q <= '0;
      err_q  <= 1'b0;
    end else if (flush) begin
      wr_q   <= '{default: '0};
      rd_q   <= '{default: '0};
      cnt_q  <= '{default: '0};
      drop_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        if (push[i]) begin
          mem_q[i][wr_q[i]] <= in_data;
          wr_q[i]           <= wr_q[i] + 1'b1;
        end
        if (pop[i]) rd_q[i] <= rd_q[i] + 1'b1;
        cnt_q[i] <= cnt_d[i];
      end
      err_q <= oor_push;
      if (oor_push && drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
    end
  end
  assign err_sel    = err_q;
  assign drop_count = drop_q;
endmodule
